// File: rtl/bus6502_initiator.sv
`default_nettype none
// bus6502_initiator: issues single 6502 bus read/write cycles (PHI2, adr, R/W, data)
// from a valid/ready command port, with a stretched PHI2-high on the YMF window.
module bus6502_initiator #(
    parameter int PH_LEN    = 1,
    parameter int YMF_EXTRA = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        phi2,
    output logic [15:0] adr,
    output logic        rw,
    output logic [7:0]  dout,
    output logic        dout_oe,
    input  logic [7:0]  din,
    output logic [7:0]  ram_bank,
    output logic [7:0]  rom_bank
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2
    } state_t;

    // Counter is loaded with (length - 1) and the phase ends when it reaches zero.
    localparam logic [4:0] PH_LAST  = 5'(PH_LEN - 1);
    localparam logic [4:0] YMF_LAST = 5'(PH_LEN + YMF_EXTRA - 1);

    state_t      state;
    logic [4:0]  phase_cnt;
    logic        lat_rw;
    logic [15:0] lat_addr;
    logic [7:0]  lat_wdata;
    logic        lat_ymf;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            phase_cnt <= 5'd0;
            lat_rw    <= 1'b1;
            lat_addr  <= 16'h0000;
            lat_wdata <= 8'h00;
            lat_ymf   <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            phi2      <= 1'b0;
            adr       <= 16'h0000;
            rw        <= 1'b1;
            dout      <= 8'h00;
            dout_oe   <= 1'b0;
            ram_bank  <= 8'h00;
            rom_bank  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (cmd_valid) begin
                        state     <= PH1;
                        phase_cnt <= PH_LAST;
                        lat_rw    <= cmd_rw;
                        lat_addr  <= cmd_addr;
                        lat_wdata <= cmd_wdata;
                        lat_ymf   <= (cmd_addr[15:1] == 15'h4FA0);
                        cmd_ready <= 1'b0;
                        adr       <= cmd_addr;
                        rw        <= cmd_rw;
                    end
                end
                PH1: begin
                    if (phase_cnt == 5'd0) begin
                        state     <= PH2;
                        phase_cnt <= lat_ymf ? YMF_LAST : PH_LAST;
                        phi2      <= 1'b1;
                        if (!lat_rw) begin
                            dout    <= lat_wdata;
                            dout_oe <= 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 5'd1;
                    end
                end
                PH2: begin
                    if (phase_cnt == 5'd0) begin
                        state     <= IDLE;
                        phase_cnt <= 5'd0;
                        phi2      <= 1'b0;
                        dout_oe   <= 1'b0;
                        rw        <= 1'b1;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= lat_rw ? din : 8'h00;
                        if (!lat_rw && lat_addr == 16'h0000) ram_bank <= lat_wdata;
                        if (!lat_rw && lat_addr == 16'h0001) rom_bank <= lat_wdata;
                    end else begin
                        phase_cnt <= phase_cnt - 5'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    phi2      <= 1'b0;
                    dout_oe   <= 1'b0;
                    rw        <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/bus6502_initiator.md
# bus6502_initiator

Initiator-side 6502 bus cycle generator for the JB6502 board: accepts single read/write commands on a valid/ready port and drives PHI2, address, R/W and data onto the system bus exactly as the CPU does. It works against the glue-logic decoder. Cycles addressed to the YMF window (0x9F40–0x9F41) get a stretched PHI2-high phase. Writes to the bank registers at 0x0000/0x0001 are mirrored into local shadow registers. It is used for DMA/boot-loader and bench traffic in place of the CPU.

## Interface
Parameters:
- PH_LEN, 1: clk cycles per PHI2 half-phase (low and high); legal range 1–15.
- YMF_EXTRA, 2: additional clk cycles of PHI2-high on YMF-window cycles; legal range 0–15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_rw  in  1  1 = read, 0 = write.
- cmd_addr  in  16  bus address.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse: cycle complete.
- rsp_rdata  out  8  read data; valid with rsp_valid.
- phi2  out  1  bus clock (sysClk equivalent).
- adr  out  16  address bus.
- rw  out  1  bus R/W, 1 = read.
- dout  out  8  write data to bus.
- dout_oe  out  1  data-bus drive enable.
- din  in  8  data bus input.
- ram_bank  out  8  shadow of bank register 0x0000.
- rom_bank  out  8  shadow of bank register 0x0001.

## Operation
- FSM states: IDLE, PH1 (PHI2 low, address phase), PH2 (PHI2 high, data phase).
- IDLE: cmd_ready=1, phi2=0, rw=1, dout_oe=0, adr holds the last value.
- Accept: on the edge with cmd_valid && cmd_ready, latch rw/addr/wdata and go to PH1. Compute is_ymf = (cmd_addr[15:1] == 15'h4FA0).
- PH1: phi2=0; adr and rw driven from the latch; dout_oe=0. Lasts PH_LEN cycles, then go to PH2.
- PH2: phi2=1; adr and rw held. On writes, dout=wdata and dout_oe=1. Lasts PH_LEN cycles, or PH_LEN+YMF_EXTRA if is_ymf.
- End of PH2 (last PH2 edge):
  - Reads: capture din into rsp_rdata. Writes: rsp_rdata=0x00.
  - Go to IDLE and assert rsp_valid for exactly one cycle.
  - In that same cycle phi2=0 and dout_oe=0. adr/rw stay at the completed cycle's values except rw, which returns to 1.
- Bank shadows, updated at the end-of-PH2 edge on writes only: address 0x0000 → ram_bank ← wdata; address 0x0001 → rom_bank ← wdata. Reads of these addresses leave the shadows unchanged.
- A phase counter of 5 bits counts down the phase length. It reloads on every state entry.
- Commands offered while not in IDLE are held off by cmd_ready=0 and are not latched.

## Timing
- Reset (rst=0 at an edge) gives, on the next cycle:
  - state=IDLE, cmd_ready=1, rsp_valid=0, rsp_rdata=0x00.
  - phi2=0, adr=0x0000, rw=1, dout=0x00, dout_oe=0.
  - ram_bank=0x00, rom_bank=0x00.
- Reset overrides everything. An in-flight command is aborted with no rsp_valid, and shadows are not updated by it.
- Cycle timeline, accept at edge T:
  - PH1 occupies cycles T+1 … T+PH_LEN.
  - PH2 occupies the following PH_LEN (+YMF_EXTRA if is_ymf) cycles.
  - rsp_valid appears in the next cycle: T+2·PH_LEN+1, plus YMF_EXTRA for YMF cycles.
- cmd_ready=1 in the rsp_valid cycle. Back-to-back issue is allowed, so the minimum command period is 2·PH_LEN+1 clks (3 at defaults; 5 for YMF at defaults).
- All outputs are registered; no combinational path from cmd_* or din to any output.
- din is sampled only at the final PH2 edge. Its value at any other time has no effect.
- YMF_EXTRA=0 gives an unstretched YMF cycle, identical in length to any other cycle.

## Test plan
- Reset: hold rst=0 for 3 clks with cmd_valid=1 → all outputs at reset values; no accept; rsp_valid never asserted.
- Read, defaults: read 0x1234 with din=0xA5 during PH2 → phi2 pattern 0,1 after accept; adr=0x1234, rw=1, dout_oe=0 throughout; rsp_valid at T+3 with rsp_rdata=0xA5.
- Write + bank shadows: write 0x0000←0x3C, then 0x0001←0x81, back-to-back → dout_oe=1 only in PH2; ram_bank=0x3C after first rsp_valid, rom_bank=0x81 after second; second accept in the first rsp_valid cycle.
- YMF stretch: write 0x9F41←0x22 with YMF_EXTRA=2 → PHI2 high for 3 clks; rsp_valid at T+5. Write 0x9F42 → PHI2 high for 1 clk (no stretch).
- Parameter sweep: PH_LEN=3, read 0x9F40 → PH1 3 clks, PH2 5 clks; rsp_valid at T+9; din changed before the last PH2 edge is ignored.
- Mid-cycle reset: rst=0 during PH2 of a write to 0x0000 → no rsp_valid; ram_bank stays 0x00; phi2=0 and dout_oe=0 next cycle.
